fifo_checker: RTL and testbench

FIFO_CHECKER -- requirements
Module: fifo_checker

---
 rtl/fifo_checker_pkg.sv | 17 +
 rtl/fifo_checker_ref.sv | 100 ++++++++++
 rtl/fifo_checker.sv | 140 ++++++++++++++
 tb/tb_fifo_checker.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_checker_pkg.sv
// Shared definitions for the FIFO scoreboard checker.
// Mismatch vector bit positions and vector type.
package fifo_checker_pkg;

  localparam int MM_FULL  = 0;
  localparam int MM_EMPTY = 1;
  localparam int MM_AF    = 2;
  localparam int MM_AE    = 3;
  localparam int MM_OVF   = 4;
  localparam int MM_UNF   = 5;
  localparam int MM_ACK   = 6;
  localparam int MM_DOUT  = 7;
  localparam int MM_W     = 8;

  typedef logic [MM_W-1:0] mm_vec_t;

endpackage

// File: rtl/fifo_checker_ref.sv
// Golden FIFO model: status flags derived from count,
// ack/overflow/underflow/read data registered.
module fifo_ref_model
  import fifo_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full_m,
  output logic                  empty_m,
  output logic                  almostfull_m,
  output logic                  almostempty_m,
  output logic                  overflow_m,
  output logic                  underflow_m,
  output logic                  wr_ack_m,
  output logic [DATA_WIDTH-1:0] data_out_m
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AF   = (AW+1)'(DEPTH - AF_MARGIN);
  localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_MARGIN);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_acc, rd_acc;

  assign full_m        = (cnt_q == CNT_FULL);
  assign empty_m       = (cnt_q == '0);
  assign almostfull_m  = (cnt_q == CNT_AF);
  assign almostempty_m = (cnt_q == CNT_AE);

  assign wr_acc = wr_en && !full_m;
  assign rd_acc = rd_en && !empty_m;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    ack_d    = wr_acc;
    ovf_d    = wr_en && full_m;
    unf_d    = rd_en && empty_m;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is never reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  assign wr_ack_m    = ack_q;
  assign overflow_m  = ovf_q;
  assign underflow_m = unf_q;
  assign data_out_m  = dout_q;

endmodule

// File: rtl/fifo_checker.sv
// Compares an observed FIFO against the golden model and
// keeps clean/error counts plus first-error capture.
module fifo_checker
  import fifo_checker_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int          DEPTH      = 8,
  parameter int          AF_MARGIN  = 1,
  parameter int          AE_MARGIN  = 1,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [7:0]  CHECK_MASK = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  almostfull,
  input  logic                  almostempty,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  wr_ack,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  test_finished,
  output logic [CNT_WIDTH-1:0]  correct_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic                  err_sticky,
  output logic [7:0]            first_err_vec,
  output logic [CNT_WIDTH-1:0]  first_err_cycle,
  output logic                  done
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                  full_m, empty_m, af_m, ae_m;
  logic                  ovf_m, unf_m, ack_m;
  logic [DATA_WIDTH-1:0] dout_m;

  fifo_ref_model #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AF_MARGIN  (AF_MARGIN),
    .AE_MARGIN  (AE_MARGIN)
  ) u_ref (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .data_in       (data_in),
    .full_m        (full_m),
    .empty_m       (empty_m),
    .almostfull_m  (af_m),
    .almostempty_m (ae_m),
    .overflow_m    (ovf_m),
    .underflow_m   (unf_m),
    .wr_ack_m      (ack_m),
    .data_out_m    (dout_m)
  );

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  mm_vec_t               mm;
  logic [CNT_WIDTH-1:0]  ok_q, ok_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0]  fcyc_q, fcyc_d;
  mm_vec_t               fvec_q, fvec_d;
  logic                  stk_q, stk_d;
  logic                  done_q, done_d;

  always_comb begin
    mm           = '0;
    mm[MM_FULL]  = (full        != full_m);
    mm[MM_EMPTY] = (empty       != empty_m);
    mm[MM_AF]    = (almostfull  != af_m);
    mm[MM_AE]    = (almostempty != ae_m);
    mm[MM_OVF]   = (overflow    != ovf_m);
    mm[MM_UNF]   = (underflow   != unf_m);
    mm[MM_ACK]   = (wr_ack      != ack_m);
    mm[MM_DOUT]  = (data_out    != dout_m);
    mm           = mm & mm_vec_t'(CHECK_MASK);
  end

  always_comb begin
    ok_d   = ok_q;
    err_d  = err_q;
    cyc_d  = cyc_q;
    fcyc_d = fcyc_q;
    fvec_d = fvec_q;
    stk_d  = stk_q;
    done_d = done_q | test_finished;
    if (!done_q) begin
      cyc_d = sat_inc(cyc_q);
      if (mm == '0) begin
        ok_d = sat_inc(ok_q);
      end else begin
        err_d = sat_inc(err_q);
        if (!stk_q) begin
          stk_d  = 1'b1;
          fvec_d = mm;
          fcyc_d = cyc_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok_q   <= '0;
      err_q  <= '0;
      cyc_q  <= '0;
      fcyc_q <= '0;
      fvec_q <= '0;
      stk_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ok_q   <= ok_d;
      err_q  <= err_d;
      cyc_q  <= cyc_d;
      fcyc_q <= fcyc_d;
      fvec_q <= fvec_d;
      stk_q  <= stk_d;
      done_q <= done_d;
    end
  end

  assign correct_count   = ok_q;
  assign error_count     = err_q;
  assign err_sticky      = stk_q;
  assign first_err_vec   = fvec_q;
  assign first_err_cycle = fcyc_q;
  assign done            = done_q;

endmodule

// File: tb/tb_fifo_checker.sv
// Directed bench for fifo_checker: drives a mirrored FIFO
// view, injects status faults and checks the counters.
module tb_fifo_checker;

  localparam int DW = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en;
  logic [DW-1:0] data_in;
  logic          full, empty, almostfull, almostempty;
  logic          overflow, underflow, wr_ack;
  logic [DW-1:0] data_out;
  logic          test_finished;
  logic [CW-1:0] correct_count, error_count, first_err_cycle;
  logic          err_sticky, done;
  logic [7:0]    first_err_vec;

  int tests = 0;
  int fails = 0;

  fifo_checker #(.CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .data_in         (data_in),
    .full            (full),
    .empty           (empty),
    .almostfull      (almostfull),
    .almostempty     (almostempty),
    .overflow        (overflow),
    .underflow       (underflow),
    .wr_ack          (wr_ack),
    .data_out        (data_out),
    .test_finished   (test_finished),
    .correct_count   (correct_count),
    .error_count     (error_count),
    .err_sticky      (err_sticky),
    .first_err_vec   (first_err_vec),
    .first_err_cycle (first_err_cycle),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One cycle of an ideal DUT at fill level cnt, with inj flipping
  // observed signals in mismatch-vector bit order.
  task automatic cyc(input logic wr, input logic rd,
                     input logic [DW-1:0] din, input int cnt,
                     input logic ov, input logic un, input logic ack,
                     input logic [DW-1:0] dout, input logic [7:0] inj);
    wr_en       = wr;
    rd_en       = rd;
    data_in     = din;
    full        = (cnt == 8) ^ inj[0];
    empty       = (cnt == 0) ^ inj[1];
    almostfull  = (cnt == 7) ^ inj[2];
    almostempty = (cnt == 1) ^ inj[3];
    overflow    = ov ^ inj[4];
    underflow   = un ^ inj[5];
    wr_ack      = ack ^ inj[6];
    data_out    = dout ^ {{(DW-1){1'b0}}, inj[7]};
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [DW-1:0] dout);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, dout, 8'h00);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ok"},   32'(correct_count),   32'd0);
    chk({tag, ".err"},  32'(error_count),     32'd0);
    chk({tag, ".stk"},  32'(err_sticky),      32'd0);
    chk({tag, ".fvec"}, 32'(first_err_vec),   32'd0);
    chk({tag, ".fcyc"}, 32'(first_err_cycle), 32'd0);
    chk({tag, ".done"}, 32'(done),            32'd0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    test_finished = 1'b0;
    idle(2, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    test_finished = 1'b0;
    @(negedge clk);

    // Reset, idle mirror, then counter saturation at 31
    do_reset();
    chk_zero("rst_a");
    idle(10, '0);
    chk("idle10.ok",  32'(correct_count), 32'd10);
    chk("idle10.err", 32'(error_count),   32'd0);
    chk("idle10.stk", 32'(err_sticky),    32'd0);
    idle(30, '0);
    chk("sat.ok",  32'(correct_count), 32'd31);
    chk("sat.err", 32'(error_count),   32'd0);

    // Fill to full, overflow write, drain in order
    do_reset();
    for (int k = 0; k < 8; k++)
      cyc(1'b1, 1'b0, 16'(k + 1), k, 1'b0, 1'b0, k > 0, '0, 8'h00);
    cyc(1'b1, 1'b0, 16'h0009, 8, 1'b0, 1'b0, 1'b1, '0, 8'h00);
    chk("fill.ok",  32'(correct_count), 32'd9);
    chk("fill.err", 32'(error_count),   32'd0);
    for (int j = 0; j < 8; j++)
      cyc(1'b0, 1'b1, '0, 8 - j, j == 0, 1'b0, 1'b0, 16'(j), 8'h00);
    cyc(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 16'h0008, 8'h00);
    chk("drain.ok",  32'(correct_count), 32'd18);
    chk("drain.err", 32'(error_count),   32'd0);
    chk("drain.stk", 32'(err_sticky),    32'd0);

    // almostfull fault at index 12, two more faults, then finish
    do_reset();
    idle(5, '0);
    for (int k = 0; k < 7; k++)
      cyc(1'b1, 1'b0, 16'(k + 1), k, 1'b0, 1'b0, k > 0, '0, 8'h00);
    cyc(1'b0, 1'b0, '0, 7, 1'b0, 1'b0, 1'b1, '0, 8'h04);
    chk("af.err",  32'(error_count),     32'd1);
    chk("af.ok",   32'(correct_count),   32'd12);
    chk("af.stk",  32'(err_sticky),      32'd1);
    chk("af.fvec", 32'(first_err_vec),   32'h04);
    chk("af.fcyc", 32'(first_err_cycle), 32'd12);
    cyc(1'b0, 1'b0, '0, 7, 1'b0, 1'b0, 1'b0, '0, 8'h01);
    cyc(1'b0, 1'b0, '0, 7, 1'b0, 1'b0, 1'b0, '0, 8'h80);
    test_finished = 1'b1;
    cyc(1'b0, 1'b0, '0, 7, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    test_finished = 1'b0;
    chk("fin.done", 32'(done),          32'd1);
    chk("fin.ok",   32'(correct_count), 32'd13);
    chk("fin.err",  32'(error_count),   32'd3);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b0, '0, 7, 1'b0, 1'b0, 1'b0, '0, 8'hFF);
    chk("frz.ok",   32'(correct_count),   32'd13);
    chk("frz.err",  32'(error_count),     32'd3);
    chk("frz.fvec", 32'(first_err_vec),   32'h04);
    chk("frz.fcyc", 32'(first_err_cycle), 32'd12);
    chk("frz.done", 32'(done),            32'd1);

    // Simultaneous request on empty FIFO
    do_reset();
    chk_zero("rst_d");
    cyc(1'b1, 1'b1, 16'hABCD, 0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    cyc(1'b0, 1'b1, '0, 1, 1'b0, 1'b1, 1'b1, '0, 8'h00);
    cyc(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 16'hABCD, 8'h00);
    chk("empty_rw.ok",  32'(correct_count), 32'd3);
    chk("empty_rw.err", 32'(error_count),   32'd0);

    // One-cycle reset at fill level 5
    do_reset();
    for (int k = 0; k < 5; k++)
      cyc(1'b1, 1'b0, 16'(16 + k), k, 1'b0, 1'b0, k > 0, '0, 8'h00);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, '0, 5, 1'b0, 1'b0, 1'b1, '0, 8'h00);
    rst_n = 1'b1;
    chk_zero("rst_mid");
    idle(3, '0);
    chk("post_rst.ok",  32'(correct_count), 32'd3);
    chk("post_rst.err", 32'(error_count),   32'd0);
    chk("post_rst.stk", 32'(err_sticky),    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
